// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID/EX interlock controller.
// Stalls ID on load-use and on dependencies on an in-flight divide, serialises
// divides (only one in flight) and squashes wrong-path work on a taken branch.
// The divider FSM is the only state; every stall/flush output is combinational
// so it acts in the same cycle as its cause.

`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH,
    parameter int DIV_CYCLES     = 32   // legal 2..255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_d,
    input  logic                      rs1_used_d,
    input  logic                      rs2_used_d,
    input  logic                      div_d,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_e,
    input  logic                      mem_read_e,
    input  logic                      div_start_e,
    input  logic                      branch_taken_e,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      flush_d,
    output logic                      flush_e,
    output logic                      div_busy,
    output logic                      div_done,
    output logic [REG_ADDR_WIDTH-1:0] div_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam logic [7:0] CNT_INIT = 8'(DIV_CYCLES - 1);

    div_state_e                state_q, state_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [REG_ADDR_WIDTH-1:0] div_rd_q, div_rd_d;

    logic rs_hit_e;     // a used ID source matches the EX destination
    logic rs_hit_div;   // a used ID source matches the in-flight divide's rd
    logic load_use;
    logic div_hazard;
    logic stall;

    // Divider state, countdown and captured destination register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            div_rd_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_rd_q <= div_rd_d;
        end
    end

    // Divider next state: a start is only honoured in IDLE; BUSY counts down
    // to zero, DONE is a single-cycle writeback slot
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_rd_d = div_rd_q;
        case (state_q)
            IDLE: begin
                if (div_start_e) begin
                    state_d  = BUSY;
                    cnt_d    = CNT_INIT;
                    div_rd_d = rd_addr_e;
                end
            end
            BUSY: begin
                if (cnt_q == 8'd0) state_d = DONE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // x0 is never a real dependency, so a zero rd matches nothing
    assign rs_hit_e   = (rd_addr_e != '0) &&
                        ((rs1_used_d && (rs1_addr_d == rd_addr_e)) ||
                         (rs2_used_d && (rs2_addr_d == rd_addr_e)));
    assign rs_hit_div = (div_rd_q != '0) &&
                        ((rs1_used_d && (rs1_addr_d == div_rd_q)) ||
                         (rs2_used_d && (rs2_addr_d == div_rd_q)));

    assign load_use = mem_read_e & rs_hit_e;

    // In the start cycle the divide is still in EX, so compare against EX's rd;
    // afterwards use the captured rd. div_d covers the one-divide-at-a-time rule.
    assign div_hazard = (state_q != IDLE) ? (rs_hit_div | div_d)
                                          : (div_start_e & (rs_hit_e | div_d));

    // Taken branch wins: the ID instruction is wrong-path and gets flushed.
    // rst_n gating forces every output low for the whole reset window.
    assign stall    = rst_n & (load_use | div_hazard) & ~branch_taken_e;
    assign stall_f  = stall;
    assign stall_d  = stall;
    assign flush_d  = rst_n & branch_taken_e;
    assign flush_e  = stall | flush_d;
    assign div_busy = (state_q == BUSY);
    assign div_done = (state_q == DONE);
    assign div_rd   = div_rd_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    localparam int W = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [W-1:0] rs1, rs2, rd_e;
    logic u1, u2, div_d, mr, st0, st1, br;

    logic sf0, sd0, fd0, fe0, bz0, dn0;
    logic sf1, sd1, fd1, fe1, bz1, dn1;
    logic [W-1:0] drd0, drd1;

    int cyc = 0;
    int ntests = 0;
    int nfail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    hazard_ctrl #(.REG_ADDR_WIDTH(W), .DIV_CYCLES(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .rs1_addr_d(rs1), .rs2_addr_d(rs2),
        .rs1_used_d(u1), .rs2_used_d(u2), .div_d(div_d), .rd_addr_e(rd_e),
        .mem_read_e(mr), .div_start_e(st0), .branch_taken_e(br),
        .stall_f(sf0), .stall_d(sd0), .flush_d(fd0), .flush_e(fe0),
        .div_busy(bz0), .div_done(dn0), .div_rd(drd0));

    hazard_ctrl #(.REG_ADDR_WIDTH(W), .DIV_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .rs1_addr_d(rs1), .rs2_addr_d(rs2),
        .rs1_used_d(u1), .rs2_used_d(u2), .div_d(div_d), .rd_addr_e(rd_e),
        .mem_read_e(mr), .div_start_e(st1), .branch_taken_e(br),
        .stall_f(sf1), .stall_d(sd1), .flush_d(fd1), .flush_e(fe1),
        .div_busy(bz1), .div_done(dn1), .div_rd(drd1));

    // Reference model: a divide issued in cycle N occupies cycles N+1..N+DC+1
    bit           iss[2];
    int           n_iss[2];
    logic [W-1:0] rdc[2];

    function automatic int dcv(input int k);
        return (k == 0) ? 32 : 2;
    endfunction

    function automatic bit infl(input int k);
        return iss[k] && (cyc >= n_iss[k] + 1) && (cyc <= n_iss[k] + dcv(k) + 1);
    endfunction

    function automatic bit hit(input logic [W-1:0] r);
        return (r != 0) && ((u1 && rs1 == r) || (u2 && rs2 == r));
    endfunction

    function automatic logic [10:0] obs(input int k);
        return (k == 0) ? {sf0, sd0, fd0, fe0, bz0, dn0, drd0}
                        : {sf1, sd1, fd1, fe1, bz1, dn1, drd1};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic idle_in();
        rs1 = 0; rs2 = 0; rd_e = 0; u1 = 0; u2 = 0;
        div_d = 0; mr = 0; st0 = 0; st1 = 0; br = 0;
    endtask

    task automatic model_reset();
        iss[0] = 0; iss[1] = 0; rdc[0] = 0; rdc[1] = 0;
        n_iss[0] = 0; n_iss[1] = 0;
    endtask

    // Check both instances against the model at the negedge, then commit starts
    task automatic sample();
        bit sk, fl, bsy, dne, hz, lu, s;
        logic [10:0] exp, act;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sk  = (k == 0) ? st0 : st1;
            fl  = infl(k);
            bsy = iss[k] && (cyc >= n_iss[k] + 1) && (cyc <= n_iss[k] + dcv(k));
            dne = iss[k] && (cyc == n_iss[k] + dcv(k) + 1);
            hz  = fl ? (hit(rdc[k]) || div_d) : (sk && (hit(rd_e) || div_d));
            lu  = mr && hit(rd_e);
            s   = (lu || hz) && !br;
            exp = {s, s, br, s || br, bsy, dne, rdc[k]};
            act = obs(k);
            ntests++;
            if (act !== exp) begin
                nfail++;
                $display("FAIL model%0d cyc %0d: got %b expected %b", k, cyc, act, exp);
            end
            if (sk) begin
                ntests++;
                if (act[6] || act[5]) begin
                    nfail++;
                    $display("FAIL start_while_active%0d cyc %0d: got busy/done %b%b expected 00",
                             k, cyc, act[6], act[5]);
                end
                if (!fl) begin
                    iss[k] = 1; n_iss[k] = cyc; rdc[k] = rd_e;
                end
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc1();
        sample();
        adv();
    endtask

    // 32-cycle divide into x7; ID reads rsv (via rs1) and/or holds a second DIV
    task automatic div32(input logic [W-1:0] rsv, input bit use1, input bit dep, input bit dd);
        idle_in();
        rd_e = 7; st0 = 1; rs1 = rsv; u1 = use1; div_d = dd;
        for (int i = 0; i <= 34; i++) begin
            sample();
            chk("div_stall", 32'(sf0), 32'((dep || dd) && i <= 33));
            chk("div_busy",  32'(bz0), 32'(i >= 1 && i <= 32));
            chk("div_done",  32'(dn0), 32'(i == 33));
            if (i == 33) chk("div_rd", 32'(drd0), 32'd7);
            adv();
            st0 = 0; rd_e = 0;
        end
        idle_in();
    endtask

    typedef struct {
        logic [W-1:0] rs1, rs2, rd;
        logic u1, u2, mr, br;
        logic [3:0] exp;   // {stall_f, stall_d, flush_d, flush_e}
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{rs1:5, rs2:0, rd:5, u1:1, u2:0, mr:1, br:0, exp:4'b1101};
        vecs[1] = '{rs1:0, rs2:0, rd:0, u1:1, u2:0, mr:1, br:0, exp:4'b0000};
        vecs[2] = '{rs1:5, rs2:0, rd:5, u1:0, u2:0, mr:1, br:0, exp:4'b0000};
        vecs[3] = '{rs1:3, rs2:5, rd:5, u1:1, u2:1, mr:1, br:0, exp:4'b1101};
        vecs[4] = '{rs1:5, rs2:0, rd:5, u1:1, u2:0, mr:0, br:0, exp:4'b0000};
        vecs[5] = '{rs1:5, rs2:0, rd:5, u1:1, u2:0, mr:1, br:1, exp:4'b0011};
        vecs[6] = '{rs1:6, rs2:0, rd:5, u1:1, u2:0, mr:1, br:0, exp:4'b0000};
        vecs[7] = '{rs1:0, rs2:0, rd:0, u1:0, u2:0, mr:0, br:1, exp:4'b0011};

        // Reset: all outputs low immediately, even with hazard inputs present
        idle_in();
        model_reset();
        rs1 = 5; u1 = 1; rd_e = 5; mr = 1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_out0", 32'(obs(0)), 32'd0);
        chk("reset_out1", 32'(obs(1)), 32'd0);
        br = 1;
        #1;
        chk("reset_br0", 32'(obs(0)), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle_in();
        adv();

        // Combinational load-use / branch vectors with the divider idle
        for (int v = 0; v < 8; v++) begin
            idle_in();
            rs1 = vecs[v].rs1; rs2 = vecs[v].rs2; rd_e = vecs[v].rd;
            u1 = vecs[v].u1; u2 = vecs[v].u2; mr = vecs[v].mr; br = vecs[v].br;
            sample();
            chk($sformatf("vec%0d", v), 32'({sf0, sd0, fd0, fe0}), 32'(vecs[v].exp));
            adv();
        end

        // Load-use holds exactly one cycle: next cycle EX carries the bubble
        idle_in();
        rs1 = 5; u1 = 1; rd_e = 5; mr = 1;
        sample();
        chk("lu_stall", 32'({sf0, sd0, fe0}), 32'b111);
        adv();
        mr = 0; rd_e = 0;
        sample();
        chk("lu_release", 32'({sf0, sd0, fe0}), 32'b000);
        adv();

        // Divide latency: independent reader, dependent reader, structural
        div32(8, 1, 0, 0);
        div32(7, 1, 1, 0);
        div32(0, 0, 0, 1);
        div32(7, 1, 1, 0);

        // DC=2 instance: BUSY 2 cycles, DONE at N+3, back-to-back start at N+4
        for (int i = 0; i <= 7; i++) begin
            idle_in();
            st1 = (i == 0 || i == 4);
            rd_e = (i == 0) ? 5'd3 : (i == 4) ? 5'd4 : 5'd0;
            sample();
            chk("d2_busy", 32'(bz1), 32'(i == 1 || i == 2 || i == 5 || i == 6));
            chk("d2_done", 32'(dn1), 32'(i == 3 || i == 7));
            if (i == 3) chk("d2_rd", 32'(drd1), 32'd3);
            if (i == 7) chk("d2_rd", 32'(drd1), 32'd4);
            adv();
        end
        idle_in();

        // Reset in BUSY cycle 10 aborts the divide
        rd_e = 7; st0 = 1;
        cyc1();
        idle_in();
        for (int i = 1; i < 10; i++) cyc1();
        rs1 = 5; u1 = 1; rd_e = 5; mr = 1;
        chk("mid_busy", 32'(bz0), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst0", 32'(obs(0)), 32'd0);
        chk("mid_rst1", 32'(obs(1)), 32'd0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle_in();
        adv();
        div32(7, 1, 1, 0);

        // Randomised traffic against the model
        for (int t = 0; t < 400; t++) begin
            rs1   = W'($urandom_range(0, 7));
            rs2   = W'($urandom_range(0, 7));
            rd_e  = W'($urandom_range(0, 7));
            u1    = 1'($urandom % 2);
            u2    = 1'($urandom % 2);
            mr    = 1'($urandom % 2);
            div_d = ($urandom % 4 == 0);
            st0   = !infl(0) && ($urandom % 6 == 0);
            st1   = !infl(1) && ($urandom % 3 == 0);
            br    = !(st0 || st1) && ($urandom % 6 == 0);
            cyc1();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline interlock controller for the five-stage RISC-V core; the producer-side counterpart of the EX operand-forwarding logic. It holds back instructions whose operands forwarding cannot supply:
- a load result one cycle too early (load-use);
- the result of the multi-cycle divider still in flight.

It also squashes wrong-path instructions on a taken branch. It sits beside the ID/EX pipeline registers and drives their stall and flush controls.

## Interface
- REG_ADDR_WIDTH, default `REG_ADDR_WIDTH` (5): register address width.
- DIV_CYCLES, default 32: divider busy cycles, legal range 2..255.
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rs1_addr_d  input  REG_ADDR_WIDTH  rs1 of the instruction in ID.
- rs2_addr_d  input  REG_ADDR_WIDTH  rs2 of the instruction in ID.
- rs1_used_d  input  1  ID instruction reads rs1.
- rs2_used_d  input  1  ID instruction reads rs2.
- div_d  input  1  ID instruction is a DIV/REM.
- rd_addr_e  input  REG_ADDR_WIDTH  rd of the instruction in EX.
- mem_read_e  input  1  EX instruction is a load.
- div_start_e  input  1  EX instruction is a DIV/REM. Asserted exactly one cycle.
- branch_taken_e  input  1  EX branch/jump redirects the PC.
- stall_f  output  1  hold PC.
- stall_d  output  1  hold the IF/ID register.
- flush_d  output  1  clear IF/ID.
- flush_e  output  1  load a bubble into ID/EX.
- div_busy  output  1  divider in BUSY state.
- div_done  output  1  divider result valid this cycle; write back to div_rd.
- div_rd  output  REG_ADDR_WIDTH  destination register of the in-flight divide.

## Operation
- Divider FSM states are IDLE, BUSY and DONE. State, counter (8 bit) and div_rd are registers; all other outputs are combinational from the registers and the inputs.
- Reset (rst_n low, asynchronous) puts the block in IDLE with counter 0 and div_rd 0. All outputs go to 0 immediately and stay 0 until the first post-reset edge.
- IDLE -> BUSY on div_start_e. At that edge: counter loads DIV_CYCLES-1 and div_rd captures rd_addr_e.
  - When rd_addr_e is 0, the FSM still runs, but no register dependency is recorded.
- BUSY: the counter decrements every cycle. At the edge where counter==0, the FSM moves to DONE.
- DONE: lasts exactly one cycle with div_done=1, then returns to IDLE. div_rd holds its value until the next start.
- div_start_e while in BUSY or DONE is illegal and ignored: no state change, div_rd is unchanged. The bench asserts that this never happens.
- load_use = mem_read_e & (rd_addr_e != 0) & ((rs1_used_d & rs1_addr_d==rd_addr_e) | (rs2_used_d & rs2_addr_d==rd_addr_e)).
- div_hazard is true in BUSY or DONE when either of these holds:
  - (div_rd != 0) and a used rs of the ID instruction equals div_rd;
  - div_d=1 (structural hazard: only one divide in flight).
- div_hazard is also true in the div_start_e cycle itself, comparing against rd_addr_e and div_d.
- stall = (load_use | div_hazard) & ~branch_taken_e.
- stall_f = stall_d = stall.
- flush_e = stall | branch_taken_e.
- flush_d = branch_taken_e.
- A taken branch has priority over every stall. The ID instruction is wrong-path, so it is flushed, not stalled.
- A divide already in flight is never cancelled by a flush, because it is older than the branch.
- div_start_e and branch_taken_e are mutually exclusive; they always come from the same EX slot.

## Timing
- Load-use: exactly one stall cycle. On the next cycle the load is in MEM, and forwarding covers the dependency.
- Divide issued at edge N: BUSY during cycles N+1..N+DIV_CYCLES, DONE in cycle N+DIV_CYCLES+1.
- div_hazard covers cycle N through cycle N+DIV_CYCLES+1. A dependent ID instruction is released in cycle N+DIV_CYCLES+2.
- Releasing after DONE means the register file holds the divide result, so no forwarding from DONE is needed.
- All stall and flush outputs respond combinationally in the same cycle as their cause. No extra latency.
- Reset asserted mid-divide aborts the divide. div_done is not produced.

## Test plan
- Load-use: load x5 in EX; ID add reads rs1=x5 with rs1_used=1 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle.
  - Same stimulus with rd_addr_e=0 -> no stall.
  - Same stimulus with rs1_used_d=0 -> no stall.
- Branch priority: load-use condition and branch_taken_e in the same cycle -> flush_d=flush_e=1, stall_f=stall_d=0.
- Divide latency, DIV_CYCLES=32: div_start_e with rd=x7 at edge N -> div_busy high for 32 cycles, div_done=1 in cycle N+33 with div_rd=7.
  - An ID instruction reading x7 stalls for cycles N..N+33 and is released in cycle N+34.
  - An ID instruction reading x8 does not stall.
- Structural hazard: second DIV in ID (div_d=1) while in BUSY -> stall for the whole divide. The second div_start_e appears only after the FSM is back in IDLE.
- Reset mid-operation: drop rst_n in BUSY cycle 10 -> all outputs 0 immediately. After release the FSM is in IDLE, and a new divide completes with full DIV_CYCLES latency.
- Wrap and boundary: DIV_CYCLES=2 -> BUSY for 2 cycles, DONE in cycle N+3.
  - A back-to-back new div_start_e in the cycle after DONE is accepted.
